// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial add/subtract sequencer sharing one full-adder slice over WIDTH cycles.
// Optional macro SERIAL_ALU_OVF_EN enables signed-overflow detection; without it ovf is tied to 0.
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] sa, sb, shifted;
    logic [WIDTH-2:0] sr;
    logic [CW-1:0] cnt;
    logic cy, accept, last, s, co;
    // one-bit full-adder slice and sequencing conditions
    always_comb begin
        accept  = start && (state != RUN);
        last    = cnt == CW'(WIDTH - 1);
        s       = sa[0] ^ sb[0] ^ cy;
        co      = (sa[0] & sb[0]) | (cy & (sa[0] ^ sb[0]));
        shifted = {s, sr};
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next state and status outputs; start is only honoured outside RUN
    always_comb begin
        state_nx = IDLE;
        busy     = state == RUN;
        done     = state == DONE;
        state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end
    // operand capture, serial processing and result commit on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            cy     <= 1'b0;
            cnt    <= '0;
            result <= '0;
            c_out  <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= op_sub ? ~b : b;
            cy  <= op_sub;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= shifted[WIDTH-1:1];
            cy  <= co;
            cnt <= cnt + CW'(1);
            if (last) begin
                result <= shifted;
                c_out  <= co;
            end
        end
    end
`ifdef SERIAL_ALU_OVF_EN
    // signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk) begin
        if (rst)                       ovf <= 1'b0;
        else if (state == RUN && last) ovf <= cy ^ co;
    end
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: directed and randomized checks of serial_alu_ctrl against an arithmetic model.
module tb_serial_alu_ctrl;
    localparam int W = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, op_sub = 1'b0;
    logic [W-1:0] a = '0, b = '0, result;
    logic busy, done, c_out, ovf;
    int checks = 0, failures = 0;
    logic [W-1:0] exp_res = '0;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Called at a negedge while idle or in the done cycle; returns at the negedge of the done cycle.
    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int r, sx, sy, sr;
        logic ec, eo;
        start = 1'b1; a = x; b = y; op_sub = s;
        @(negedge clk);
        for (int i = 0; i < W; i++) begin
            chk("run_busy", 32'(busy), 1);
            chk("run_done", 32'(done), 0);
            chk("run_result_held", 32'(result), 32'(exp_res));
            start = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            op_sub = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        r  = s ? int'(x) - int'(y) : int'(x) + int'(y);
        ec = s ? (x >= y) : (r >= 2 ** W);
        sx = (int'(x) >= 2 ** (W - 1)) ? int'(x) - 2 ** W : int'(x);
        sy = (int'(y) >= 2 ** (W - 1)) ? int'(y) - 2 ** W : int'(y);
        sr = s ? sx - sy : sx + sy;
`ifdef SERIAL_ALU_OVF_EN
        eo = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
`else
        eo = 1'b0;
`endif
        exp_res = W'(r);
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("result", 32'(result), 32'(exp_res));
        chk("c_out", 32'(c_out), 32'(ec));
        chk("ovf", 32'(ovf), 32'(eo));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_result", 32'(result), 0);
        chk("reset_c_out", 32'(c_out), 0);
        chk("reset_ovf", 32'(ovf), 0);
        op(8'h25, 8'h17, 1'b0);
        @(negedge clk); chk_idle("gap1");
        op(8'hFF, 8'h01, 1'b0);
        @(negedge clk); chk_idle("gap2");
        op(8'h7F, 8'h01, 1'b0);
        @(negedge clk); chk_idle("gap3");
        op(8'h10, 8'h20, 1'b1);
        op(8'h20, 8'h10, 1'b1);
        @(negedge clk); chk_idle("gap4");
        op(8'h33, 8'h44, 1'b0);
        @(negedge clk); chk_idle("gap5");
        start = 1'b1; a = 8'h5A; b = 8'h3C; op_sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_res = '0;
        chk_idle("midrun_rst");
        chk("midrun_rst_result", 32'(result), 0);
        chk("midrun_rst_c_out", 32'(c_out), 0);
        chk("midrun_rst_ovf", 32'(ovf), 0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            chk_idle("post_rst");
        end
        repeat (30) begin
            op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk_idle("rand_gap");
            end
        end
        @(negedge clk);
        chk_idle("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
